// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_ctrl
// Brief    : Byte-addressable little-endian data memory with a valid/ready
//            request/response handshake, wait states and access fault checks.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_ctrl #(
    parameter int MEM_BYTES   = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [31:0] i_req_addr,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_fault,
    output logic [1:0]  o_rsp_fault_code
);

    localparam int          c_ADDR_W    = $clog2(MEM_BYTES);
    localparam logic [32:0] c_MEM_BYTES = 33'(MEM_BYTES);
    localparam logic [3:0]  c_WAIT      = 4'(WAIT_CYCLES);

    localparam logic [1:0] c_SZ_BYTE = 2'b00;
    localparam logic [1:0] c_SZ_HALF = 2'b01;
    localparam logic [1:0] c_SZ_WORD = 2'b10;
    localparam logic [1:0] c_SZ_ILL  = 2'b11;

    localparam logic [1:0] c_FC_NONE  = 2'b00;
    localparam logic [1:0] c_FC_MISAL = 2'b01;
    localparam logic [1:0] c_FC_RANGE = 2'b10;
    localparam logic [1:0] c_FC_SIZE  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_RESP = 2'b10
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_cnt;
    logic                r_we;
    logic [31:0]         r_addr;
    logic [1:0]          r_size;
    logic                r_uns;
    logic [31:0]         r_wdata;
    logic [31:0]         r_rdata;
    logic                r_fault;
    logic [1:0]          r_code;
    logic [7:0]          r_mem [MEM_BYTES];

    logic [32:0]         w_nbytes;
    logic [32:0]         w_last;
    logic                w_oor;
    logic                w_misal;
    logic [1:0]          w_code;
    logic                w_fault;
    logic                w_access;
    logic                w_wr;
    logic [c_ADDR_W-1:0] w_idx0;
    logic [c_ADDR_W-1:0] w_idx1;
    logic [c_ADDR_W-1:0] w_idx2;
    logic [c_ADDR_W-1:0] w_idx3;
    logic [31:0]         w_load;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_req_valid)   w_state_nxt = S_WAIT;
            S_WAIT:  if (r_cnt == 4'd0) w_state_nxt = S_RESP;
            S_RESP:  if (i_rsp_ready)   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- Fault decode (33-bit so the range check cannot wrap) ----------------
    always_comb begin
        w_nbytes = 33'd4;
        case (r_size)
            c_SZ_BYTE: w_nbytes = 33'd1;
            c_SZ_HALF: w_nbytes = 33'd2;
            default:   w_nbytes = 33'd4;
        endcase
    end

    assign w_last  = {1'b0, r_addr} + w_nbytes - 33'd1;
    assign w_oor   = (w_last >= c_MEM_BYTES);
    assign w_misal = ((r_size == c_SZ_HALF) && r_addr[0]) ||
                     ((r_size == c_SZ_WORD) && (r_addr[1:0] != 2'b00));

    always_comb begin
        w_code = c_FC_NONE;
        if (r_size == c_SZ_ILL) begin
            w_code = c_FC_SIZE;
        end else if (w_oor) begin
            w_code = c_FC_RANGE;
        end else if (w_misal) begin
            w_code = c_FC_MISAL;
        end
    end

    assign w_fault  = (w_code != c_FC_NONE);
    assign w_access = (r_state == S_WAIT) && (r_cnt == 4'd0);
    assign w_wr     = w_access && r_we && !w_fault;

    // ---------------- Memory array ----------------
    assign w_idx0 = r_addr[c_ADDR_W-1:0];
    assign w_idx1 = w_idx0 + c_ADDR_W'(1);
    assign w_idx2 = w_idx0 + c_ADDR_W'(2);
    assign w_idx3 = w_idx0 + c_ADDR_W'(3);

    always_comb begin
        w_load = {r_mem[w_idx3], r_mem[w_idx2], r_mem[w_idx1], r_mem[w_idx0]};
        case (r_size)
            c_SZ_BYTE: w_load = {{24{~r_uns & r_mem[w_idx0][7]}}, r_mem[w_idx0]};
            c_SZ_HALF: w_load = {{16{~r_uns & r_mem[w_idx1][7]}}, r_mem[w_idx1], r_mem[w_idx0]};
            default:   w_load = {r_mem[w_idx3], r_mem[w_idx2], r_mem[w_idx1], r_mem[w_idx0]};
        endcase
    end

    // Contents are deliberately not reset; a reset forces IDLE so no write can slip through.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[w_idx0] <= r_wdata[7:0];
            if (r_size != c_SZ_BYTE) begin
                r_mem[w_idx1] <= r_wdata[15:8];
            end
            if (r_size == c_SZ_WORD) begin
                r_mem[w_idx2] <= r_wdata[23:16];
                r_mem[w_idx3] <= r_wdata[31:24];
            end
        end
    end

    // ---------------- Request latch, wait counter and response registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_size  <= 2'b00;
            r_uns   <= 1'b0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_fault <= 1'b0;
            r_code  <= c_FC_NONE;
        end else if ((r_state == S_IDLE) && i_req_valid) begin
            r_we    <= i_req_we;
            r_addr  <= i_req_addr;
            r_size  <= i_req_size;
            r_uns   <= i_req_unsigned;
            r_wdata <= i_req_wdata;
            r_cnt   <= c_WAIT;
        end else if (r_state == S_WAIT) begin
            if (r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end else begin
                r_rdata <= (w_fault || r_we) ? 32'd0 : w_load;
                r_fault <= w_fault;
                r_code  <= w_code;
            end
        end
    end

    assign o_req_ready      = (r_state == S_IDLE);
    assign o_rsp_valid      = (r_state == S_RESP);
    assign o_rsp_rdata      = r_rdata;
    assign o_rsp_fault      = r_fault;
    assign o_rsp_fault_code = r_code;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_ctrl
// Brief    : Self-checking bench: directed table, corner sequences and a
//            randomized run against a byte-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_ctrl;

    localparam int N_DUT = 3;

    logic        clk;
    logic        rst_n          [N_DUT];
    logic        req_valid      [N_DUT];
    logic        req_ready      [N_DUT];
    logic        req_we         [N_DUT];
    logic [31:0] req_addr       [N_DUT];
    logic [1:0]  req_size       [N_DUT];
    logic        req_uns        [N_DUT];
    logic [31:0] req_wdata      [N_DUT];
    logic        rsp_valid      [N_DUT];
    logic        rsp_ready      [N_DUT];
    logic [31:0] rsp_rdata      [N_DUT];
    logic        rsp_fault      [N_DUT];
    logic [1:0]  rsp_code       [N_DUT];

    int checks = 0;
    int errors = 0;

    // Instance 0: no wait states, instance 1: three, instance 2: four
    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        data_mem_ctrl #(
            .MEM_BYTES   (1024),
            .WAIT_CYCLES ((g == 0) ? 0 : ((g == 1) ? 3 : 4))
        ) u_dut (
            .clk              (clk),
            .rst_n            (rst_n[g]),
            .i_req_valid      (req_valid[g]),
            .o_req_ready      (req_ready[g]),
            .i_req_we         (req_we[g]),
            .i_req_addr       (req_addr[g]),
            .i_req_size       (req_size[g]),
            .i_req_unsigned   (req_uns[g]),
            .i_req_wdata      (req_wdata[g]),
            .o_rsp_valid      (rsp_valid[g]),
            .i_rsp_ready      (rsp_ready[g]),
            .o_rsp_rdata      (rsp_rdata[g]),
            .o_rsp_fault      (rsp_fault[g]),
            .o_rsp_fault_code (rsp_code[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One full transaction; lat = edges from accept to Rsp_Valid, -1 on timeout.
    task automatic xfer(input int k, input logic we, input logic [31:0] a, input logic [1:0] sz,
                        input logic u, input logic [31:0] wd, output logic [31:0] rd,
                        output logic f, output logic [1:0] fc, output int lat);
        int guard;
        guard = 0;
        rd = 32'd0; f = 1'b0; fc = 2'b00; lat = -1;
        @(negedge clk);
        while (!req_ready[k] && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 64) begin
            errors++;
            $display("FAIL ready_timeout: dut %0d never ready", k);
            return;
        end
        req_valid[k] = 1'b1; req_we[k] = we; req_addr[k] = a;
        req_size[k] = sz; req_uns[k] = u; req_wdata[k] = wd;
        @(posedge clk);
        #1 req_valid[k] = 1'b0;
        lat = 0;
        while (!rsp_valid[k] && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!rsp_valid[k]) begin
            errors++;
            $display("FAIL rsp_timeout: dut %0d no response", k);
            lat = -1;
            return;
        end
        rd = rsp_rdata[k]; f = rsp_fault[k]; fc = rsp_code[k];
        @(negedge clk);
        rsp_ready[k] = 1'b1;
        @(posedge clk);
        #1 rsp_ready[k] = 1'b0;
    endtask

    // ---------------- Reference model (instance 0) ----------------
    logic [7:0] mm [1024];

    function automatic void model(input logic we, input logic [31:0] a, input logic [1:0] sz,
                                  input logic u, input logic [31:0] wd, output logic [31:0] rd,
                                  output logic f, output logic [1:0] fc);
        int     n;
        longint last;
        longint val;
        rd = 32'd0; f = 1'b0; fc = 2'b00;
        if (sz == 2'b11) begin
            f = 1'b1; fc = 2'b11;
            return;
        end
        n    = 1 << sz;
        last = longint'({32'd0, a}) + n - 1;
        if (last >= 1024) begin
            f = 1'b1; fc = 2'b10;
            return;
        end
        if ((a % n) != 0) begin
            f = 1'b1; fc = 2'b01;
            return;
        end
        if (we) begin
            for (int i = 0; i < n; i++) mm[int'(a) + i] = 8'((wd >> (8 * i)) & 32'hFF);
        end else begin
            val = 0;
            for (int i = 0; i < n; i++) val = val + (longint'(mm[int'(a) + i]) << (8 * i));
            if (!u && n < 4 && ((val >> (8 * n - 1)) & 1) == 1) val = val - (longint'(1) << (8 * n));
            rd = 32'(val);
        end
    endfunction

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        f;
        logic [1:0]  fc;
    } vec_t;

    function automatic vec_t mk(string nm, logic we, logic [31:0] a, logic [1:0] sz, logic u,
                                logic [31:0] wd, logic [31:0] rd, logic f, logic [1:0] fc);
        vec_t v;
        v.name = nm; v.we = we; v.addr = a; v.size = sz; v.uns = u;
        v.wd = wd; v.rd = rd; v.f = f; v.fc = fc;
        return v;
    endfunction

    vec_t tbl [21];

    initial begin
        logic [31:0] rd, erd, held;
        logic        f, ef;
        logic [1:0]  fc, efc;
        int          lat;

        tbl[0]  = mk("st_w_10",     1, 32'h10,       2'b10, 0, 32'hDEADBEEF, 32'h0,        0, 2'b00);
        tbl[1]  = mk("ld_bs_11",    0, 32'h11,       2'b00, 0, 32'h0,        32'hFFFFFFBE, 0, 2'b00);
        tbl[2]  = mk("ld_hu_12",    0, 32'h12,       2'b01, 1, 32'h0,        32'h0000DEAD, 0, 2'b00);
        tbl[3]  = mk("ld_hs_12",    0, 32'h12,       2'b01, 0, 32'h0,        32'hFFFFDEAD, 0, 2'b00);
        tbl[4]  = mk("ld_bu_13",    0, 32'h13,       2'b00, 1, 32'h0,        32'h000000DE, 0, 2'b00);
        tbl[5]  = mk("st_h_13_mis", 1, 32'h13,       2'b01, 0, 32'h1234,     32'h0,        1, 2'b01);
        tbl[6]  = mk("ld_hu_12_b",  0, 32'h12,       2'b01, 1, 32'h0,        32'h0000DEAD, 0, 2'b00);
        tbl[7]  = mk("ld_w_3fe",    0, 32'h3FE,      2'b10, 0, 32'h0,        32'h0,        1, 2'b10);
        tbl[8]  = mk("ill_3ff",     0, 32'h3FF,      2'b11, 0, 32'h0,        32'h0,        1, 2'b11);
        tbl[9]  = mk("st_w_20",     1, 32'h20,       2'b10, 0, 32'h11223344, 32'h0,        0, 2'b00);
        tbl[10] = mk("st_b_21",     1, 32'h21,       2'b00, 0, 32'hFFFFFF5A, 32'h0,        0, 2'b00);
        tbl[11] = mk("ld_w_20",     0, 32'h20,       2'b10, 0, 32'h0,        32'h11225A44, 0, 2'b00);
        tbl[12] = mk("st_w_3fc",    1, 32'h3FC,      2'b10, 0, 32'hCAFEF00D, 32'h0,        0, 2'b00);
        tbl[13] = mk("ld_w_3fc",    0, 32'h3FC,      2'b10, 1, 32'h0,        32'hCAFEF00D, 0, 2'b00);
        tbl[14] = mk("ld_bu_3ff",   0, 32'h3FF,      2'b00, 1, 32'h0,        32'h000000CA, 0, 2'b00);
        tbl[15] = mk("ld_h_3ff",    0, 32'h3FF,      2'b01, 0, 32'h0,        32'h0,        1, 2'b10);
        tbl[16] = mk("ill_10",      1, 32'h10,       2'b11, 0, 32'h0,        32'h0,        1, 2'b11);
        tbl[17] = mk("ld_w_12_mis", 0, 32'h12,       2'b10, 0, 32'h0,        32'h0,        1, 2'b01);
        tbl[18] = mk("ld_w_wrap",   0, 32'hFFFFFFFC, 2'b10, 0, 32'h0,        32'h0,        1, 2'b10);
        tbl[19] = mk("st_b_400",    1, 32'h400,      2'b00, 0, 32'h77,       32'h0,        1, 2'b10);
        tbl[20] = mk("ld_w_10",     0, 32'h10,       2'b10, 1, 32'h0,        32'hDEADBEEF, 0, 2'b00);

        for (int k = 0; k < N_DUT; k++) begin
            rst_n[k] = 1'b0; req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = 32'd0;
            req_size[k] = 2'b00; req_uns[k] = 1'b0; req_wdata[k] = 32'd0; rsp_ready[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < N_DUT; k++) begin
            chk($sformatf("rst_ready%0d", k), 32'(req_ready[k]), 32'd1);
            chk($sformatf("rst_valid%0d", k), 32'(rsp_valid[k]), 32'd0);
            chk($sformatf("rst_rdata%0d", k), rsp_rdata[k], 32'd0);
            chk($sformatf("rst_fault%0d", k), {rsp_fault[k], 29'd0, rsp_code[k]}, 32'd0);
        end
        @(negedge clk);
        for (int k = 0; k < N_DUT; k++) rst_n[k] = 1'b1;

        // ---------------- Directed table on zero-wait instance ----------------
        for (int i = 0; i < 21; i++) begin
            xfer(0, tbl[i].we, tbl[i].addr, tbl[i].size, tbl[i].uns, tbl[i].wd, rd, f, fc, lat);
            chk({tbl[i].name, "_rdata"}, rd, tbl[i].rd);
            chk({tbl[i].name, "_fault"}, {f, 29'd0, fc}, {tbl[i].f, 29'd0, tbl[i].fc});
            chk({tbl[i].name, "_lat"}, 32'(lat), 32'd1);
        end

        // ---------------- Randomized run against the model ----------------
        for (int w = 0; w < 256; w++) begin
            logic [31:0] d;
            d = $urandom;
            model(1'b1, 32'(w * 4), 2'b10, 1'b0, d, erd, ef, efc);
            xfer(0, 1'b1, 32'(w * 4), 2'b10, 1'b0, d, rd, f, fc, lat);
        end
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a, d;
            logic [1:0]  sz;
            logic        we, u;
            int          r;
            r  = $urandom_range(0, 9);
            if (r < 7)      a = 32'($urandom_range(0, 1023));
            else if (r < 9) a = 32'($urandom_range(1016, 1040));
            else            a = $urandom;
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            if (sz != 2'b11 && $urandom_range(0, 1) == 1) a = a & ~((32'd1 << sz) - 32'd1);
            we = 1'($urandom_range(0, 1));
            u  = 1'($urandom_range(0, 1));
            d  = $urandom;
            model(we, a, sz, u, d, erd, ef, efc);
            xfer(0, we, a, sz, u, d, rd, f, fc, lat);
            if (rd !== erd || f !== ef || fc !== efc) begin
                chk($sformatf("rnd%0d_a%08h_sz%0d_we%0d", n, a, sz, we), {rd[30:0], f} ^ {29'd0, fc, 1'b0}, {erd[30:0], ef} ^ {29'd0, efc, 1'b0});
                chk($sformatf("rnd%0d_rdata", n), rd, erd);
            end else begin
                chk($sformatf("rnd%0d", n), rd, erd);
            end
        end

        // ---------------- Three wait states: latency and response hold ----------------
        xfer(1, 1'b1, 32'h10, 2'b10, 1'b0, 32'hA5A55A5A, rd, f, fc, lat);
        chk("w3_store_lat", 32'(lat), 32'd4);
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'h10; req_size[1] = 2'b10;
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk);
            #1;
            chk($sformatf("w3_valid_e%0d", e), 32'(rsp_valid[1]), (e == 4) ? 32'd1 : 32'd0);
        end
        held = rsp_rdata[1];
        chk("w3_load_data", held, 32'hA5A55A5A);
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h10; req_wdata[1] = 32'h0;
        for (int e = 0; e < 5; e++) begin
            @(posedge clk);
            #1;
            chk($sformatf("w3_hold_valid%0d", e), 32'(rsp_valid[1]), 32'd1);
            chk($sformatf("w3_hold_data%0d", e), rsp_rdata[1], 32'hA5A55A5A);
            chk($sformatf("w3_hold_ready%0d", e), 32'(req_ready[1]), 32'd0);
        end
        @(negedge clk);
        req_valid[1] = 1'b0; rsp_ready[1] = 1'b1;
        @(posedge clk);
        #1 rsp_ready[1] = 1'b0;
        chk("w3_release_valid", 32'(rsp_valid[1]), 32'd0);
        chk("w3_release_ready", 32'(req_ready[1]), 32'd1);
        xfer(1, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, rd, f, fc, lat);
        chk("w3_ignored_store", rd, 32'hA5A55A5A);

        // ---------------- Four wait states: reset aborts WAIT and discards RESP ----------------
        xfer(2, 1'b1, 32'h30, 2'b10, 1'b0, 32'h01020304, rd, f, fc, lat);
        chk("w4_store_lat", 32'(lat), 32'd5);
        @(negedge clk);
        req_valid[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = 32'h30; req_size[2] = 2'b10;
        req_wdata[2] = 32'hFFFFFFFF;
        @(posedge clk);
        #1 req_valid[2] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n[2] = 1'b0;
        #1;
        chk("w4_rst_ready", 32'(req_ready[2]), 32'd1);
        chk("w4_rst_valid", 32'(rsp_valid[2]), 32'd0);
        @(negedge clk);
        rst_n[2] = 1'b1;
        for (int e = 0; e < 8; e++) begin
            @(posedge clk);
            #1;
            chk($sformatf("w4_abort_valid%0d", e), 32'(rsp_valid[2]), 32'd0);
        end
        xfer(2, 1'b0, 32'h30, 2'b10, 1'b0, 32'h0, rd, f, fc, lat);
        chk("w4_old_data", rd, 32'h01020304);
        chk("w4_post_rst_lat", 32'(lat), 32'd5);

        @(negedge clk);
        req_valid[2] = 1'b1; req_we[2] = 1'b0; req_addr[2] = 32'h30; req_size[2] = 2'b00;
        req_uns[2] = 1'b0;
        @(posedge clk);
        #1 req_valid[2] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("w4_resp_before_rst", 32'(rsp_valid[2]), 32'd1);
        chk("w4_resp_data", rsp_rdata[2], 32'h00000004);
        @(negedge clk);
        rst_n[2] = 1'b0;
        #1;
        chk("w4_rst_discard_valid", 32'(rsp_valid[2]), 32'd0);
        chk("w4_rst_discard_rdata", rsp_rdata[2], 32'd0);
        @(negedge clk);
        rst_n[2] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("w4_discard_stays", 32'(rsp_valid[2]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 The block SHALL take parameter MEM_BYTES, default 1024, giving byte-addressable capacity; it must be a power of two and at least 4.
REQ-002 The block SHALL take parameter WAIT_CYCLES, default 0, giving extra access wait states; the range is 0-15.
REQ-003 Clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Rst_n  input  1  asynchronous, active-low reset.
REQ-005 Req_Valid  input  1  request present.
REQ-006 Req_Ready  output  1  block can accept a request.
REQ-007 Req_WE  input  1  1 = store, 0 = load.
REQ-008 Req_Addr  input  32  byte address.
REQ-009 Req_Size  input  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-010 Req_Unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
REQ-011 Req_WData  input  32  store data, right-aligned.
REQ-012 Rsp_Valid  output  1  response present.
REQ-013 Rsp_Ready  input  1  consumer accepts the response.
REQ-014 Rsp_RData  output  32  load result after extension; 0 for stores and faults.
REQ-015 Rsp_Fault  output  1  request was rejected.
REQ-016 Rsp_Fault_Code  output  2  fault cause: 00 none, 01 misaligned, 10 out-of-range, 11 illegal size.

Function
REQ-017 Storage SHALL be MEM_BYTES bytes in little-endian order; contents are not reset.
REQ-018 The FSM SHALL have three states, IDLE, WAIT and RESP, encoded with two bits.
REQ-019 Req_Ready SHALL be 1 only in IDLE.
REQ-020 In IDLE, Req_Valid=1 at an edge SHALL latch all Req_* fields, load the wait counter with WAIT_CYCLES, and move to WAIT.
REQ-021 In WAIT with counter != 0, the block SHALL decrement the counter; with counter == 0, it SHALL perform the access, register the response, and move to RESP.
REQ-022 Rsp_Valid SHALL rise exactly WAIT_CYCLES+1 edges after the accept edge; with WAIT_CYCLES=0, that is the next edge.
REQ-023 In RESP, Rsp_Valid=1 SHALL be held, with Rsp_RData, Rsp_Fault and Rsp_Fault_Code stable, until an edge with Rsp_Ready=1; the FSM then returns to IDLE.
REQ-024 Sustained throughput SHALL be one request per WAIT_CYCLES+3 cycles, with no overlap between requests.
REQ-025 Fault priority SHALL be: illegal size (11) > out-of-range > misaligned.
REQ-026 A request is out-of-range when Req_Addr + access bytes - 1 >= MEM_BYTES; this check SHALL use 33-bit arithmetic, with no wrap-around.
REQ-027 A request is misaligned when the size is half and Addr[0]=1, or the size is word and Addr[1:0] != 00; bytes are never misaligned.
REQ-028 A faulted request SHALL leave memory unchanged and return Rsp_RData=0 and Rsp_Fault=1.
REQ-029 A store SHALL write only the addressed 1, 2 or 4 bytes, from WData[7:0] upward; all other bytes are untouched.
REQ-030 A byte load SHALL extend bit 7 (signed) or zero; a half load SHALL extend bit 15 (signed) or zero; a word load is passed unchanged, and Req_Unsigned is ignored.
REQ-031 Req_Valid while Req_Ready=0 SHALL be ignored; the requester holds it until accepted.

Reset
REQ-032 Asserting Rst_n=0 SHALL immediately force the state to IDLE, the counter to 0, Req_Ready=1, Rsp_Valid=0, Rsp_RData=0, Rsp_Fault=0 and Rsp_Fault_Code=00.
REQ-033 A reset during WAIT SHALL abort the pending access, so an aborted store leaves memory unchanged.
REQ-034 A reset during RESP SHALL discard the response.
REQ-035 After Rst_n deasserts, the first request SHALL be accepted at the first edge with Req_Valid=1.

Verification
REQ-036 WAIT_CYCLES=0: store word 0xDEADBEEF @0x10, then load byte signed @0x11 -> Rsp_RData=0xFFFFFFBE; then load half unsigned @0x12 -> Rsp_RData=0x0000DEAD.
REQ-037 WAIT_CYCLES=3: load word @0x10 accepted at edge N -> Rsp_Valid=1 at edge N+4; hold Rsp_Ready=0 for 5 cycles -> data stable, Req_Ready=0 throughout.
REQ-038 Fault cases:
- store half @0x13 -> Fault code 01, memory @0x12-0x13 unchanged;
- load word @0x3FE (MEM_BYTES=1024) -> code 10;
- Req_Size=11 @0x3FF -> code 11.
REQ-039 Byte store 0x5A @0x21 over word 0x11223344 @0x20 -> word load @0x20 returns 0x11225A44.
REQ-040 WAIT_CYCLES=4: store accepted, Rst_n pulsed low during WAIT -> Rsp_Valid stays 0, a later load shows the old data, and Req_Ready=1 during reset.
